// File: rtl/fir_accumulator_if.sv
// Handshake/data bundle between the FIR tap datapath, fir_accumulator and its consumer.
// master: datapath + downstream side; slave: fir_accumulator.
interface fir_accumulator_if #(
  parameter int unsigned IN_W  = 51,
  parameter int unsigned OUT_W = 24
) ();
  logic [1:0]            count;
  logic                  valid;
  logic [4:0][IN_W-1:0]  sub_prod_i;
  logic [4:0][IN_W-1:0]  sub_prod_q;
  logic                  Stall;
  logic                  out_valid;
  logic                  out_ready;
  logic [OUT_W-1:0]      out_i;
  logic [OUT_W-1:0]      out_q;
  logic                  sat_flag;
  logic                  ovf_err;

  modport master (
    output count, valid, sub_prod_i, sub_prod_q, out_ready,
    input  Stall, out_valid, out_i, out_q, sat_flag, ovf_err
  );

  modport slave (
    input  count, valid, sub_prod_i, sub_prod_q, out_ready,
    output Stall, out_valid, out_i, out_q, sat_flag, ovf_err
  );
endinterface

// File: rtl/fir_accumulator.sv
// Sums five complex FIR sub-products, rounds/saturates 4.47 -> 1.23 and queues results in a
// credit-controlled output FIFO. Define FIR_ACC_SATCNT_EN to add the sat_count output.
module fir_accumulator #(
  parameter int unsigned OUT_DEPTH = 4,
  parameter int unsigned IN_W      = 51,
  parameter int unsigned OUT_W     = 24
) (
  input  logic             Clk,
  input  logic             Reset,
  fir_accumulator_if.slave bus
`ifdef FIR_ACC_SATCNT_EN
  ,
  output logic [15:0]      sat_count
`endif
);
  localparam int unsigned NPROD = 5;
  localparam int unsigned SUM_W = IN_W + 3;
  localparam int unsigned SHIFT = IN_W - 3 - OUT_W;
  localparam int unsigned R_W   = SUM_W - SHIFT;
  localparam int unsigned PTR_W = $clog2(OUT_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned CR_W  = CNT_W + 1;
  localparam logic signed [SUM_W-1:0] BIAS = SUM_W'(1) <<< (SHIFT - 1);

  typedef struct packed {
    logic [OUT_W-1:0] i;
    logic [OUT_W-1:0] q;
    logic             sat;
  } entry_t;

  logic                        v1;
  logic                        v2;
  logic [NPROD-1:0][IN_W-1:0]  cap_i;
  logic [NPROD-1:0][IN_W-1:0]  cap_q;
  logic signed [SUM_W-1:0]     sum_i;
  logic signed [SUM_W-1:0]     sum_q;
  logic signed [SUM_W-1:0]     sum_i_c;
  logic signed [SUM_W-1:0]     sum_q_c;
  logic [OUT_W-1:0]            rnd_i_c;
  logic [OUT_W-1:0]            rnd_q_c;
  logic                        sat_i_c;
  logic                        sat_q_c;
  entry_t                      res_c;
  entry_t                      head_c;
  entry_t                      mem [OUT_DEPTH];
  logic [PTR_W-1:0]            wr_ptr;
  logic [PTR_W-1:0]            rd_ptr;
  logic [CNT_W-1:0]            fifo_cnt;
  logic                        nonempty_c;
  logic                        full_c;
  logic                        pop_c;
  logic                        push_c;
  logic                        drop_c;
  logic                        capture_c;
  logic [CR_W-1:0]             credit_c;
  logic                        ovf_err_r;

  // Round half-up then clamp; returns {sat, value}.
  function automatic logic [OUT_W:0] round_sat(input logic signed [SUM_W-1:0] s);
    logic signed [R_W-1:0] r;
    logic [R_W-OUT_W:0]    top;
    r   = R_W'((s + BIAS) >>> SHIFT);
    top = r[R_W-1:OUT_W-1];
    if ((&top) || !(|top))
      round_sat = {1'b0, r[OUT_W-1:0]};
    else if (r[R_W-1])
      round_sat = {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
    else
      round_sat = {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
  endfunction

  always_comb begin
    sum_i_c = '0;
    sum_q_c = '0;
    for (int k = 0; k < NPROD; k++) begin
      sum_i_c = sum_i_c + SUM_W'($signed(cap_i[k]));
      sum_q_c = sum_q_c + SUM_W'($signed(cap_q[k]));
    end
  end

  always_comb begin
    {sat_i_c, rnd_i_c} = round_sat(sum_i);
    {sat_q_c, rnd_q_c} = round_sat(sum_q);
    res_c.i    = rnd_i_c;
    res_c.q    = rnd_q_c;
    res_c.sat  = sat_i_c | sat_q_c;
    capture_c  = bus.valid && (bus.count == 2'd2);
    nonempty_c = (fifo_cnt != '0);
    full_c     = (fifo_cnt == CNT_W'(OUT_DEPTH));
    pop_c      = nonempty_c && bus.out_ready;
    // A full FIFO can still accept when the head leaves in the same cycle.
    push_c     = v2 && (!full_c || pop_c);
    drop_c     = v2 && full_c && !pop_c;
    credit_c   = CR_W'(fifo_cnt) + CR_W'(v1) + CR_W'(v2);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      cap_i     <= '0;
      cap_q     <= '0;
      sum_i     <= '0;
      sum_q     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      ovf_err_r <= 1'b0;
    end else begin
      v1 <= capture_c;
      if (capture_c) begin
        cap_i <= bus.sub_prod_i;
        cap_q <= bus.sub_prod_q;
      end
      v2    <= v1;
      sum_i <= sum_i_c;
      sum_q <= sum_q_c;
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_cnt <= fifo_cnt + CNT_W'(push_c) - CNT_W'(pop_c);
      if (drop_c) ovf_err_r <= 1'b1;
    end
  end

  // Storage is not reset; the head is masked while the FIFO is empty.
  always_ff @(posedge Clk) begin
    if (push_c) mem[wr_ptr] <= res_c;
  end

  assign head_c        = mem[rd_ptr];
  assign bus.out_valid = nonempty_c;
  assign bus.out_i     = nonempty_c ? head_c.i : '0;
  assign bus.out_q     = nonempty_c ? head_c.q : '0;
  assign bus.sat_flag  = nonempty_c ? head_c.sat : 1'b0;
  assign bus.ovf_err   = ovf_err_r;
  assign bus.Stall     = (credit_c >= CR_W'(OUT_DEPTH - 1));

`ifdef FIR_ACC_SATCNT_EN
  always_ff @(posedge Clk) begin
    if (Reset)
      sat_count <= '0;
    else if (push_c && res_c.sat && (sat_count != 16'hFFFF))
      sat_count <= sat_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_fir_accumulator.sv
// Self-checking bench for fir_accumulator: directed scenarios plus randomized sequences
// compared every cycle against a queue-based behavioural model.
module tb_fir_accumulator;
  localparam int unsigned IN_W  = 51;
  localparam int unsigned OUT_W = 24;
  localparam int unsigned DEPTH = 4;

  typedef logic [4:0][IN_W-1:0] prod_t;
  typedef struct {
    logic [OUT_W-1:0] i;
    logic [OUT_W-1:0] q;
    logic             sat;
  } exp_t;

  logic Clk;
  logic Reset;
`ifdef FIR_ACC_SATCNT_EN
  logic [15:0] sat_count;
`endif

  fir_accumulator_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  fir_accumulator #(.OUT_DEPTH(DEPTH), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
`ifdef FIR_ACC_SATCNT_EN
    ,
    .sat_count (sat_count)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int   n_tests;
  int   n_fail;
  int   dut_pops;
  exp_t m_fifo[$];
  exp_t m_p1;
  exp_t m_p2;
  logic m_p1v;
  logic m_p2v;
  logic m_ovf;
  int   m_satcnt;

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Fixed-point reference: exact integer sum, round half-up, clamp to 1.23.
  function automatic void comp(input prod_t p, output logic [OUT_W-1:0] v, output logic s);
    longint sum;
    longint r;
    sum = 0;
    for (int k = 0; k < 5; k++) sum += longint'($signed(p[k]));
    r = (sum + 64'sd8388608) >>> 24;
    if (r > 64'sd8388607) begin
      v = 24'h7FFFFF; s = 1'b1;
    end else if (r < -64'sd8388608) begin
      v = 24'h800000; s = 1'b1;
    end else begin
      v = OUT_W'(r); s = 1'b0;
    end
  endfunction

  function automatic exp_t model_calc(input prod_t pi, input prod_t pq);
    exp_t e;
    logic si;
    logic sq;
    comp(pi, e.i, si);
    comp(pq, e.q, sq);
    e.sat = si | sq;
    return e;
  endfunction

  // Advance the model by one rising edge using the inputs the bench is driving.
  task automatic model_edge();
    logic pop;
    if (Reset) begin
      m_fifo.delete();
      m_p1v = 1'b0; m_p2v = 1'b0; m_ovf = 1'b0; m_satcnt = 0;
      return;
    end
    pop = (m_fifo.size() != 0) && bus.out_ready;
    if (pop) void'(m_fifo.pop_front());
    if (m_p2v) begin
      if (m_fifo.size() >= int'(DEPTH)) m_ovf = 1'b1;
      else begin
        m_fifo.push_back(m_p2);
        if (m_p2.sat && m_satcnt != 65535) m_satcnt++;
      end
    end
    m_p2v = m_p1v;
    m_p2  = m_p1;
    m_p1v = bus.valid && (bus.count == 2'd2);
    if (m_p1v) m_p1 = model_calc(bus.sub_prod_i, bus.sub_prod_q);
  endtask

  task automatic check_outputs();
    logic exp_stall;
    exp_stall = (m_fifo.size() + int'(m_p1v) + int'(m_p2v)) >= int'(DEPTH - 1);
    check("out_valid", longint'(bus.out_valid), longint'(m_fifo.size() != 0));
    if (m_fifo.size() != 0) begin
      check("out_i", longint'(bus.out_i), longint'(m_fifo[0].i));
      check("out_q", longint'(bus.out_q), longint'(m_fifo[0].q));
      check("sat_flag", longint'(bus.sat_flag), longint'(m_fifo[0].sat));
    end else begin
      check("out_i_empty", longint'(bus.out_i), 0);
      check("out_q_empty", longint'(bus.out_q), 0);
      check("sat_empty", longint'(bus.sat_flag), 0);
    end
    check("stall", longint'(bus.Stall), longint'(exp_stall));
    check("ovf_err", longint'(bus.ovf_err), longint'(m_ovf));
`ifdef FIR_ACC_SATCNT_EN
    check("sat_count", longint'(sat_count), longint'(m_satcnt));
`endif
  endtask

  task automatic tick();
    if (bus.out_valid && bus.out_ready) dut_pops++;
    @(posedge Clk);
    model_edge();
    @(negedge Clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    bus.valid = 1'b0;
    bus.count = 2'd0;
    repeat (n) tick();
  endtask

  // Idle cycles with noise that must never capture (valid with count 0/1/3, or valid low).
  task automatic rand_idle(input int n);
    int c;
    repeat (n) begin
      c = $urandom_range(0, 2);
      if (c == 2) c = 3;
      bus.valid = 1'($urandom_range(0, 1));
      bus.count = 2'(c);
      tick();
    end
    bus.valid = 1'b0;
    bus.count = 2'd0;
  endtask

  task automatic run_seq(input prod_t pi, input prod_t pq);
    bus.sub_prod_i = pi;
    bus.sub_prod_q = pq;
    bus.valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      bus.count = 2'(c);
      tick();
    end
    bus.valid = 1'b0;
    bus.count = 2'd0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    bus.valid = 1'b0;
    bus.count = 2'd0;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  function automatic logic [IN_W-1:0] rand_prod();
    longint v;
    int     sh;
    sh = $urandom_range(20, 50);
    v  = longint'({$urandom, $urandom});
    v  = v >>> (63 - sh);
    return IN_W'(v);
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    prod_t pi;
    prod_t pq;
    int    issued;
    int    waited;

    n_tests = 0; n_fail = 0; dut_pops = 0;
    m_p1v = 1'b0; m_p2v = 1'b0; m_ovf = 1'b0; m_satcnt = 0;
    m_p1 = '{default: '0}; m_p2 = '{default: '0};
    bus.out_ready = 1'b0;
    bus.sub_prod_i = '0;
    bus.sub_prod_q = '0;
    do_reset();
    check("rst_valid", longint'(bus.out_valid), 0);
    check("rst_stall", longint'(bus.Stall), 0);
    check("rst_out_i", longint'(bus.out_i), 0);
    check("rst_ovf", longint'(bus.ovf_err), 0);

    // Basic latency: sum = 10.0 saturates positive.
    bus.out_ready = 1'b1;
    pq = '0;
    for (int k = 0; k < 5; k++) pi[k] = IN_W'(longint'(k) <<< 47);
    run_seq(pi, pq);
    tick();
    check("lat_2cyc_valid", longint'(bus.out_valid), 0);
    tick();
    check("lat_3cyc_valid", longint'(bus.out_valid), 1);
    check("lat_out_i", longint'(bus.out_i), 64'h7FFFFF);
    check("lat_out_q", longint'(bus.out_q), 0);
    check("lat_sat", longint'(bus.sat_flag), 1);
    idle(2);

    // Rounding at exactly half an output LSB, and just below it.
    pi = '0;
    pi[0] = IN_W'(64'h80_0000);
    run_seq(pi, pq);
    idle(2);
    check("rnd_half_valid", longint'(bus.out_valid), 1);
    check("rnd_half", longint'(bus.out_i), 1);
    check("rnd_half_sat", longint'(bus.sat_flag), 0);
    idle(1);
    pi[0] = IN_W'(64'h7F_FFFF);
    run_seq(pi, pq);
    idle(2);
    check("rnd_below_valid", longint'(bus.out_valid), 1);
    check("rnd_below", longint'(bus.out_i), 0);
    idle(1);

    // Negative saturation: -5.0 and -1.25.
    for (int k = 0; k < 5; k++) pi[k] = IN_W'(-(64'sd1 <<< 47));
    run_seq(pi, pq);
    idle(2);
    check("neg5_out_i", longint'(bus.out_i), 64'h800000);
    check("neg5_sat", longint'(bus.sat_flag), 1);
    idle(1);
    for (int k = 0; k < 5; k++) pi[k] = IN_W'(-(64'sd1 <<< 45));
    run_seq(pi, pq);
    idle(2);
    check("neg125_out_i", longint'(bus.out_i), 64'h800000);
    check("neg125_sat", longint'(bus.sat_flag), 1);
    idle(2);

    // Randomized sequences honouring Stall, random backpressure and capture noise.
    for (int n = 0; n < 40; n++) begin
      waited = 0;
      while (bus.Stall && waited < 200) begin
        bus.out_ready = 1'b1;
        idle(1);
        waited++;
      end
      if (waited >= 200) check("stall_timeout", 1, 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 5; k++) begin
        pi[k] = rand_prod();
        pq[k] = rand_prod();
      end
      run_seq(pi, pq);
      bus.out_ready = ($urandom_range(0, 1) != 0);
      rand_idle($urandom_range(0, 3));
    end
    bus.out_ready = 1'b1;
    idle(10);
    check("rand_drained", longint'(bus.out_valid), 0);

    // Backpressure: issue while Stall is low, then drain.
    do_reset();
    bus.out_ready = 1'b0;
    issued = 0;
    for (int s = 0; s < 6; s++) begin
      if (bus.Stall) break;
      pi = '0; pq = '0;
      pi[0] = IN_W'(longint'(s + 1) <<< 40);
      pq[1] = IN_W'(-(longint'(s + 1) <<< 38));
      run_seq(pi, pq);
      issued++;
    end
    check("bp_issued", longint'(issued), 3);
    check("bp_stall", longint'(bus.Stall), 1);
    idle(4);
    check("bp_ovf", longint'(bus.ovf_err), 0);
    dut_pops = 0;
    bus.out_ready = 1'b1;
    idle(6);
    check("bp_drain", longint'(dut_pops), 3);

    // Overflow: five captures with no drain.
    do_reset();
    bus.out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      pi = '0; pq = '0;
      pi[2] = IN_W'(longint'(s + 1) <<< 36);
      run_seq(pi, pq);
    end
    idle(3);
    check("ovf_set", longint'(bus.ovf_err), 1);
    dut_pops = 0;
    bus.out_ready = 1'b1;
    idle(8);
    check("ovf_kept", longint'(dut_pops), 4);
    check("ovf_sticky", longint'(bus.ovf_err), 1);
    do_reset();
    check("ovf_clr", longint'(bus.ovf_err), 0);

    // Reset mid-operation with v1=v2=1 and two queued entries.
    bus.out_ready = 1'b0;
    bus.valid = 1'b1;
    bus.count = 2'd2;
    for (int s = 0; s < 4; s++) begin
      pi = '0; pq = '0;
      pi[0] = IN_W'(longint'(s + 1) <<< 44);
      bus.sub_prod_i = pi;
      bus.sub_prod_q = pq;
      tick();
    end
    check("mr_pre_valid", longint'(bus.out_valid), 1);
    check("mr_pre_stall", longint'(bus.Stall), 1);
    Reset = 1'b1;
    bus.valid = 1'b0;
    bus.count = 2'd0;
    tick();
    check("mr_valid", longint'(bus.out_valid), 0);
    check("mr_stall", longint'(bus.Stall), 0);
    check("mr_ovf", longint'(bus.ovf_err), 0);
    check("mr_out_i", longint'(bus.out_i), 0);
    Reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      idle(1);
      check("mr_stale", longint'(bus.out_valid), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
